// File: rtl/rgb565_pixel_assembler.sv
// rgb565_pixel_assembler
//
// Packs a byte stream (high byte first) into 16-bit RGB565 words and writes
// them to the panel framebuffer at a linear row-major address.
//
// Input handshake: data_in is consumed on every rising edge where
// data_in_valid=1. There is no ready/backpressure in either direction. The
// framebuffer must accept one pixel_we strobe per cycle. pixel_out and
// pixel_addr are meaningful only while pixel_we=1, and they hold their value
// between strobes.
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous, active-high
//   data_in        received byte
//   data_in_valid  single-cycle strobe per byte
//   frame_start    one-cycle pulse: restart at address 0, expect high byte
//   pixel_out      {hi_byte, lo_byte} = rrrrrggg_gggbbbbb
//   pixel_addr     row*PIXEL_WIDTH + column
//   pixel_we       one-cycle write strobe
//   frame_done     pulses with pixel_we of the last pixel in the frame
//   byte_timeout   pulses when a pending high byte is discarded
module rgb565_pixel_assembler #(
  parameter int PIXEL_WIDTH    = 64,
  parameter int PIXEL_HEIGHT   = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int ADDR_W        = $clog2(PIXEL_WIDTH * PIXEL_HEIGHT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        data_in,
  input  logic              data_in_valid,
  input  logic              frame_start,
  output logic [15:0]       pixel_out,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              pixel_we,
  output logic              frame_done,
  output logic              byte_timeout
);

  localparam int COL_W = $clog2(PIXEL_WIDTH);
  localparam int ROW_W = (PIXEL_HEIGHT > 1) ? $clog2(PIXEL_HEIGHT) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(PIXEL_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(PIXEL_HEIGHT - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [7:0]         hi_reg;
  logic [TO_W-1:0]    tcnt;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic [ADDR_W-1:0]  ptr;

  logic               to_expire;
  logic               at_last;
  logic               take_hi;
  logic               take_lo;
  logic               fire_to;
  logic               tcnt_inc;

  assign to_expire = (tcnt == TO_LAST);
  assign at_last   = (col == COL_LAST) && (row == ROW_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT_HI;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state. frame_start outranks everything; a byte arriving with it
  // becomes the first high byte of the new frame.
  always_comb begin
    state_nxt = state;
    if (frame_start) begin
      state_nxt = data_in_valid ? WAIT_LO : WAIT_HI;
    end else begin
      case (state)
        WAIT_HI: if (data_in_valid) state_nxt = WAIT_LO;
        WAIT_LO: begin
          if (data_in_valid)  state_nxt = WAIT_HI;
          else if (to_expire) state_nxt = WAIT_HI;
        end
        default: state_nxt = WAIT_HI;
      endcase
    end
  end

  // FSM actions. A pending high byte dropped by frame_start does not count
  // as a timeout.
  always_comb begin
    take_hi  = 1'b0;
    take_lo  = 1'b0;
    fire_to  = 1'b0;
    tcnt_inc = 1'b0;
    if (frame_start) begin
      take_hi = data_in_valid;
    end else begin
      case (state)
        WAIT_HI: take_hi = data_in_valid;
        WAIT_LO: begin
          take_lo  = data_in_valid;
          fire_to  = !data_in_valid && to_expire;
          tcnt_inc = !data_in_valid && !to_expire;
        end
        default: ;
      endcase
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_reg       <= '0;
      tcnt         <= '0;
      col          <= '0;
      row          <= '0;
      ptr          <= '0;
      pixel_out    <= '0;
      pixel_addr   <= '0;
      pixel_we     <= 1'b0;
      frame_done   <= 1'b0;
      byte_timeout <= 1'b0;
    end else begin
      pixel_we     <= take_lo;
      frame_done   <= take_lo && at_last;
      byte_timeout <= fire_to;

      if (take_hi) begin
        hi_reg <= data_in;
      end

      if (take_hi) begin
        tcnt <= '0;
      end else if (tcnt_inc) begin
        tcnt <= tcnt + TO_W'(1);
      end

      if (take_lo) begin
        pixel_out  <= {hi_reg, data_in};
        pixel_addr <= ptr;
        // The linear pointer runs beside col/row so the address needs no
        // multiplier; both wrap together at the last pixel.
        if (at_last) begin
          col <= '0;
          row <= '0;
          ptr <= '0;
        end else if (col == COL_LAST) begin
          col <= '0;
          row <= row + ROW_W'(1);
          ptr <= ptr + ADDR_W'(1);
        end else begin
          col <= col + COL_W'(1);
          ptr <= ptr + ADDR_W'(1);
        end
      end

      if (frame_start) begin
        col <= '0;
        row <= '0;
        ptr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rgb565_pixel_assembler.sv
module tb_rgb565_pixel_assembler;

  localparam int W  = 64;
  localparam int H  = 32;
  localparam int T  = 1024;
  localparam int AW = 11;
  localparam int EW = 1 + AW + 16;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    data_in = '0;
  logic          data_in_valid = 1'b0;
  logic          frame_start = 1'b0;
  logic [15:0]   pixel_out;
  logic [AW-1:0] pixel_addr;
  logic          pixel_we;
  logic          frame_done;
  logic          byte_timeout;

  always #5 clk = ~clk;

  rgb565_pixel_assembler #(
    .PIXEL_WIDTH(W),
    .PIXEL_HEIGHT(H),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .reset(reset),
    .data_in(data_in),
    .data_in_valid(data_in_valid),
    .frame_start(frame_start),
    .pixel_out(pixel_out),
    .pixel_addr(pixel_addr),
    .pixel_we(pixel_we),
    .frame_done(frame_done),
    .byte_timeout(byte_timeout)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int to_seen = 0;
  int exp_to = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end #1 after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    data_in       = b;
    data_in_valid = 1'b1;
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
  endtask

  task automatic expect_px(input logic [AW-1:0] a, input logic [15:0] d, input logic fd);
    exp_q.push_back({fd, a, d});
  endtask

  task automatic pixel(input logic [AW-1:0] a, input logic [7:0] hi, input logic [7:0] lo,
                       input logic fd);
    expect_px(a, {hi, lo}, fd);
    send(hi);
    send(lo);
  endtask

  task automatic fs(input logic with_byte, input logic [7:0] b);
    data_in       = b;
    data_in_valid = with_byte;
    frame_start   = 1'b1;
    @(posedge clk);
    #1;
    frame_start   = 1'b0;
    data_in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      idle(1);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_out"},  pixel_out, 0);
    check({tag, "_addr"}, pixel_addr, 0);
    check({tag, "_we"},   pixel_we, 0);
    check({tag, "_fd"},   frame_done, 0);
    check({tag, "_to"},   byte_timeout, 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (byte_timeout) to_seen++;
    if (frame_done && !pixel_we) begin
      total++;
      bad++;
      $display("FAIL frame_done_alone actual=1 required=0");
    end
    if (pixel_we) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write actual=we addr=0x%0h data=0x%0h required=no write",
                 pixel_addr, pixel_out);
      end else begin
        e = exp_q.pop_front();
        if ({frame_done, pixel_addr, pixel_out} !== e) begin
          bad++;
          $display("FAIL pixel actual=fd%0b/0x%0h/0x%0h required=fd%0b/0x%0h/0x%0h",
                   frame_done, pixel_addr, pixel_out, e[EW-1], e[EW-2:16], e[15:0]);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] a;

    // Reset state
    idle(3);
    check_outputs_zero("reset");
    reset = 1'b0;
    idle(2);

    // Single pixel after reset
    pixel(11'd0, 8'hF8, 8'h1F, 1'b0);
    drain("single_drain");

    // Full frame, data equal to address, then wrap to 0
    fs(1'b0, 8'h00);
    for (int i = 0; i < W * H; i++) begin
      a = 16'(i);
      expect_px(AW'(i), a, (i == W * H - 1));
      send(a[15:8]);
      send(a[7:0]);
    end
    pixel(11'd0, 8'hBE, 8'hEF, 1'b0);
    drain("frame_drain");

    // Timeout: pointer now at 1
    send(8'hAA);
    idle(T - 1);
    check("timeout_early", to_seen, exp_to);
    exp_to++;
    idle(2);
    check("timeout_fire", to_seen, exp_to);
    idle(5);
    check("timeout_once", to_seen, exp_to);
    check("timeout_no_write", exp_q.size(), 0);
    pixel(11'd1, 8'h12, 8'h34, 1'b0);
    drain("timeout_drain");

    // Mid-frame resync: pointer now at 2
    for (int i = 0; i < 10; i++) begin
      pixel(AW'(2 + i), 8'(i), 8'(8'h40 + i), 1'b0);
    end
    send(8'h99);
    idle(2);
    fs(1'b0, 8'h00);
    idle(3);
    pixel(11'd0, 8'hAB, 8'hCD, 1'b0);
    drain("resync_drain");
    check("resync_no_timeout", to_seen, exp_to);

    // frame_start with a byte in the same cycle: pointer at 1 beforehand
    fs(1'b1, 8'h55);
    expect_px(11'd0, 16'h5566, 1'b0);
    send(8'h66);
    drain("fs_byte_drain");

    // Reset one cycle after a high byte
    send(8'h77);
    reset = 1'b1;
    idle(1);
    check_outputs_zero("midreset");
    idle(2);
    check_outputs_zero("midreset_hold");
    reset = 1'b0;
    idle(1);
    pixel(11'd0, 8'h01, 8'h02, 1'b0);
    drain("reset_drain");
    check("final_timeouts", to_seen, exp_to);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rgb565_pixel_assembler.md
# rgb565_pixel_assembler

Assembles a stream of bytes (high byte first) into 16-bit RGB565 pixel words and writes them to the panel framebuffer. Each word goes out with a write strobe and a linear address. The block sits directly upstream of the RGB565-to-6-bit channel expander: framebuffer words it writes are later read back and expanded for the display driver. It also provides frame resynchronisation, an inter-byte timeout to recover from a lost byte, and an end-of-frame pulse.

## Interface
- PIXEL_WIDTH, 64, panel columns (≥2)
- PIXEL_HEIGHT, 32, panel rows (≥1)
- TIMEOUT_CYCLES, 1024, max clk cycles allowed between high and low byte (≥2)
- ADDR_W (localparam), $clog2(PIXEL_WIDTH*PIXEL_HEIGHT), address width
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- data_in  input  8  received byte
- data_in_valid  input  1  data_in valid this cycle (single-cycle strobe per byte)
- frame_start  input  1  one-cycle pulse: restart at address 0, expect high byte
- pixel_out  output  16  assembled word {hi_byte, lo_byte} = rrrrrggg_gggbbbbb
- pixel_addr  output  ADDR_W  linear address, row*PIXEL_WIDTH + column
- pixel_we  output  1  one-cycle write strobe for pixel_out/pixel_addr
- frame_done  output  1  one-cycle pulse coincident with pixel_we of last pixel
- byte_timeout  output  1  one-cycle pulse when a pending high byte is discarded

## Operation
- Two-state FSM:
  - WAIT_HI:
    - On data_in_valid: latch data_in into hi_reg, clear timeout counter, go to WAIT_LO.
  - WAIT_LO:
    - On data_in_valid: register pixel_out={hi_reg,data_in}, pixel_addr=write pointer, assert pixel_we next cycle, advance pointer, go to WAIT_HI.
    - Otherwise increment timeout counter.
    - On reaching TIMEOUT_CYCLES-1 without a byte: discard hi_reg, pulse byte_timeout, go to WAIT_HI. Pointer is unchanged.
- Write pointer:
  - Column counter 0..PIXEL_WIDTH-1; on wrap, row counter increments.
  - After row PIXEL_HEIGHT-1, col PIXEL_WIDTH-1, both wrap to 0.
  - pixel_addr is the concatenated/linear value; no gaps between rows.
- frame_done asserts when the written pixel is at the final address (row H-1, col W-1).
- frame_start has priority over everything:
  - Pointer goes to 0 and FSM to WAIT_HI; any pending high byte is dropped silently (no byte_timeout).
  - If data_in_valid is high in the same cycle, that byte is taken as the new frame's high byte; FSM goes to WAIT_LO.
- Reset values: pixel_out=0, pixel_addr=0, pixel_we=0, frame_done=0, byte_timeout=0, FSM=WAIT_HI, pointer=0, timeout counter=0.
- Reset asserted mid-pixel drops the partial byte; no write is issued.

## Timing
- Latency:
  - Low byte accepted at edge N.
  - pixel_we, pixel_out, pixel_addr and frame_done are valid during the cycle after N.
  - All are registered outputs.
- Back-to-back bytes on consecutive cycles are supported; sustained throughput is 1 pixel per 2 cycles.
- pixel_out and pixel_addr hold their values between strobes. Consumers sample only when pixel_we=1.
- byte_timeout is registered: it is high for the one cycle after the counter reaches TIMEOUT_CYCLES-1.
  - A byte arriving in that same cycle is treated as a new high byte.
- No backpressure: the framebuffer write port must accept one write every cycle.

## Test plan
- Single pixel after reset, bytes 0xF8 then 0x1F:
  - pixel_we pulses once one cycle after the second byte.
  - pixel_out=0xF81F, pixel_addr=0.
- Full frame of 64×32 pixels with the data word equal to its address:
  - 2048 writes at addresses 0..2047 in order.
  - frame_done only with address 2047.
  - Next pixel wraps to address 0.
- High byte 0xAA, then idle for 1024 cycles:
  - byte_timeout pulses once and there is no pixel_we.
  - Next pair 0x12, 0x34 writes 0x1234 to the unchanged address.
- Mid-frame resync:
  - Write 10 pixels, send one high byte, then frame_start.
  - Next pair 0xAB, 0xCD writes 0xABCD at address 0; no byte_timeout.
- frame_start and data_in_valid (0x55) in the same cycle, followed by 0x66:
  - Write 0x5566 at address 0.
- reset asserted one cycle after a high byte, then pair 0x01, 0x02:
  - No write during reset.
  - Afterwards 0x0102 is written at address 0.
  - All outputs read 0 while reset is held.
